// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment encoder/capture pair: glyph table,
// blank pattern, scan FSM states and small anode-bus helpers.
package sevenseg_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [1:0] digit_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURED
    } scan_state_t;

    localparam int NUM_DIGITS = 4;

    // All segments off (active-low)
    localparam seg_t SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} glyphs, index = hex value (entry 0 is the LSB slice)
    localparam logic [15:0][6:0] GLYPHS = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Encoder-side lookup, kept next to the table so both sides stay in sync
    function automatic seg_t glyph_of(input logic [3:0] value);
        return GLYPHS[value];
    endfunction

    // Number of anodes currently driven (low) on the scan bus
    function automatic logic [2:0] count_low(input logic [3:0] an);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an[i]) n = n + 3'd1;
        end
        return n;
    endfunction

    // Index of the lowest active (low) anode; only meaningful for one-hot-low buses
    function automatic digit_idx_t low_index(input logic [3:0] an);
        digit_idx_t idx;
        idx = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (!an[i]) idx = digit_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sevenseg_scan_capture_if.sv
// Scan bus plus reconstructed-display results. The master side drives the
// scanned segment/anode bus; the slave side (the capture block) reports
// what the display is showing.
interface sevenseg_scan_capture_if;
    import sevenseg_pkg::*;

    seg_t       cathode;
    logic [3:0] an;

    seg_t       digit0;
    seg_t       digit1;
    seg_t       digit2;
    seg_t       digit3;
    logic [3:0] hex0;
    logic [3:0] hex1;
    logic [3:0] hex2;
    logic [3:0] hex3;
    logic [3:0] hex_valid;
    logic       frame_done;
    logic       stable;
    logic       scan_err;

    modport master (
        output cathode, an,
        input  digit0, digit1, digit2, digit3,
        input  hex0, hex1, hex2, hex3, hex_valid,
        input  frame_done, stable, scan_err
    );

    modport slave (
        input  cathode, an,
        output digit0, digit1, digit2, digit3,
        output hex0, hex1, hex2, hex3, hex_valid,
        output frame_done, stable, scan_err
    );

endinterface

// File: rtl/sevenseg_glyph_decode.sv
// Turns an active-low segment pattern back into its hex value. Patterns that
// are not one of the sixteen glyphs decode to 0 with valid low.
module sevenseg_glyph_decode
    import sevenseg_pkg::*;
(
    input  seg_t       pattern,
    output logic       valid,
    output logic [3:0] hex
);

    // Table search over the shared glyph set; glyphs are unique so at most one hits
    always_comb begin
        valid = 1'b0;
        hex   = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == GLYPHS[i]) begin
                valid = 1'b1;
                hex   = 4'(i);
            end
        end
    end

endmodule

// File: rtl/sevenseg_scan_capture.sv
// Watches a multiplexed 4-digit seven-segment scan bus, captures each digit once
// its anode/cathode pair has held still long enough, and publishes whole frames
// atomically with decoded values, a frame pulse, stability and a sticky
// multi-anode error flag.
module sevenseg_scan_capture
    import sevenseg_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int STABLE_FRAMES = 2
) (
    input logic clk,
    input logic reset,
    sevenseg_scan_capture_if.slave bus
);

    localparam int SCW = $clog2(SETTLE_CYCLES + 1);
    localparam int FCW = $clog2(STABLE_FRAMES + 1);
    localparam logic [SCW-1:0] SETTLE_ONE = SCW'(1);
    localparam logic [SCW-1:0] SETTLE_MAX = SCW'(SETTLE_CYCLES);
    localparam logic [FCW-1:0] FRAME_ONE  = FCW'(1);
    localparam logic [FCW-1:0] STABLE_MAX = FCW'(STABLE_FRAMES);

    logic [3:0]     an_q;
    logic [3:0]     an_p;
    seg_t           cat_q;
    seg_t           cat_p;

    scan_state_t    state;
    logic [SCW-1:0] settle_cnt;
    seg_t           shadow  [NUM_DIGITS];
    seg_t           digit_r [NUM_DIGITS];
    logic [3:0]     mask;
    logic [FCW-1:0] frame_cnt;
    logic [FCW-1:0] frame_cnt_next;
    logic           frame_done_r;
    logic           stable_r;
    logic           scan_err_r;

    logic [2:0]     an_lows;
    logic           an_blank;
    logic           an_onehot;
    logic           an_changed;
    logic           cat_changed;
    logic           frame_same;

    logic           dec_valid [NUM_DIGITS];
    logic [3:0]     dec_hex   [NUM_DIGITS];

    // Register the raw bus once, and keep the previous registered copy for change detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q  <= 4'hF;
            an_p  <= 4'hF;
            cat_q <= SEG_BLANK;
            cat_p <= SEG_BLANK;
        end else begin
            an_q  <= bus.an;
            an_p  <= an_q;
            cat_q <= bus.cathode;
            cat_p <= cat_q;
        end
    end

    // Classify the registered anode bus and spot any movement since last cycle
    always_comb begin
        an_lows     = count_low(an_q);
        an_blank    = (an_lows == 3'd0);
        an_onehot   = (an_lows == 3'd1);
        an_changed  = (an_q != an_p);
        cat_changed = (cat_q != cat_p);
    end

    // Next stability count: the first frame after reset or any changed frame restarts at 1
    always_comb begin
        frame_same = (shadow[0] == digit_r[0]) && (shadow[1] == digit_r[1]) &&
                     (shadow[2] == digit_r[2]) && (shadow[3] == digit_r[3]);
        if ((frame_cnt == '0) || !frame_same) begin
            frame_cnt_next = FRAME_ONE;
        end else if (frame_cnt >= STABLE_MAX) begin
            frame_cnt_next = STABLE_MAX;
        end else begin
            frame_cnt_next = frame_cnt + FRAME_ONE;
        end
    end

    // Scan FSM with digit capture, plus atomic frame publish and stability tracking.
    // Publish clears the mask before the capture branch, so a same-cycle capture
    // (not reachable with the settle timing, but harmless) still lands in the mask.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            mask         <= 4'h0;
            frame_cnt    <= '0;
            frame_done_r <= 1'b0;
            stable_r     <= 1'b0;
            scan_err_r   <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i]  <= SEG_BLANK;
                digit_r[i] <= SEG_BLANK;
            end
        end else begin
            frame_done_r <= 1'b0;

            if (mask == 4'hF) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    digit_r[i] <= shadow[i];
                end
                mask         <= 4'h0;
                frame_done_r <= 1'b1;
                frame_cnt    <= frame_cnt_next;
                stable_r     <= (frame_cnt_next >= STABLE_MAX);
            end

            case (state)
                IDLE: begin
                    if (!an_blank) begin
                        state      <= SETTLE;
                        settle_cnt <= SETTLE_ONE;
                    end
                end
                SETTLE: begin
                    if (an_blank) begin
                        state <= IDLE;
                    end else if (an_changed || cat_changed) begin
                        settle_cnt <= SETTLE_ONE;
                    end else if (settle_cnt >= SETTLE_MAX) begin
                        if (an_onehot) begin
                            shadow[low_index(an_q)] <= cat_q;
                            mask[low_index(an_q)]   <= 1'b1;
                        end else begin
                            scan_err_r <= 1'b1;
                        end
                        state <= CAPTURED;
                    end else begin
                        settle_cnt <= settle_cnt + SETTLE_ONE;
                    end
                end
                CAPTURED: begin
                    if (an_changed) begin
                        if (an_blank) begin
                            state <= IDLE;
                        end else begin
                            state      <= SETTLE;
                            settle_cnt <= SETTLE_ONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // One decoder per published digit, so hex values always track the published frame
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        sevenseg_glyph_decode u_dec (
            .pattern (digit_r[g]),
            .valid   (dec_valid[g]),
            .hex     (dec_hex[g])
        );
    end

    assign bus.digit0     = digit_r[0];
    assign bus.digit1     = digit_r[1];
    assign bus.digit2     = digit_r[2];
    assign bus.digit3     = digit_r[3];
    assign bus.hex0       = dec_hex[0];
    assign bus.hex1       = dec_hex[1];
    assign bus.hex2       = dec_hex[2];
    assign bus.hex3       = dec_hex[3];
    assign bus.hex_valid  = {dec_valid[3], dec_valid[2], dec_valid[1], dec_valid[0]};
    assign bus.frame_done = frame_done_r;
    assign bus.stable     = stable_r;
    assign bus.scan_err   = scan_err_r;

endmodule

// File: tb/tb_sevenseg_scan_capture.sv
// Directed bench for the seven-segment scan capture block: frame reconstruction,
// stability, glitch rejection, multi-anode error, illegal glyphs and reset.
module tb_sevenseg_scan_capture;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   frames_seen;
    logic stable_at_done;
    int   f0;

    sevenseg_scan_capture_if bus ();

    sevenseg_scan_capture #(
        .SETTLE_CYCLES (4),
        .STABLE_FRAMES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count publish pulses and remember stable as it was alongside each pulse
    always @(negedge clk) begin
        if (bus.frame_done === 1'b1) begin
            frames_seen++;
            stable_at_done = bus.stable;
        end
    end

    // Hold one anode/cathode pair for n cycles, starting on a falling edge
    task automatic dwell(input logic [3:0] a, input logic [6:0] c, input int n);
        bus.an      = a;
        bus.cathode = c;
        repeat (n) @(negedge clk);
    endtask

    // Full scan digit0..digit3 followed by a short blank gap
    task automatic scan_frame(input logic [6:0] c0, input logic [6:0] c1,
                              input logic [6:0] c2, input logic [6:0] c3, input int n);
        dwell(4'b1110, c0, n);
        dwell(4'b1101, c1, n);
        dwell(4'b1011, c2, n);
        dwell(4'b0111, c3, n);
        dwell(4'b1111, 7'h7F, 3);
    endtask

    // Synchronous-looking reset pulse with the bus blanked
    task automatic apply_reset();
        bus.an      = 4'hF;
        bus.cathode = 7'h7F;
        reset       = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        reset = 1'b1;
        #1;
        checks++; if (bus.digit0 !== 7'h7F) begin errors++; $display("[TB] FAIL reset digit0 got=%h exp=7f", bus.digit0); end
        checks++; if (bus.digit1 !== 7'h7F) begin errors++; $display("[TB] FAIL reset digit1 got=%h exp=7f", bus.digit1); end
        checks++; if (bus.digit2 !== 7'h7F) begin errors++; $display("[TB] FAIL reset digit2 got=%h exp=7f", bus.digit2); end
        checks++; if (bus.digit3 !== 7'h7F) begin errors++; $display("[TB] FAIL reset digit3 got=%h exp=7f", bus.digit3); end
        checks++; if (bus.hex0 !== 4'h0) begin errors++; $display("[TB] FAIL reset hex0 got=%h exp=0", bus.hex0); end
        checks++; if (bus.hex3 !== 4'h0) begin errors++; $display("[TB] FAIL reset hex3 got=%h exp=0", bus.hex3); end
        checks++; if (bus.hex_valid !== 4'h0) begin errors++; $display("[TB] FAIL reset hex_valid got=%b exp=0000", bus.hex_valid); end
        checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset frame_done got=%b exp=0", bus.frame_done); end
        checks++; if (bus.stable !== 1'b0) begin errors++; $display("[TB] FAIL reset stable got=%b exp=0", bus.stable); end
        checks++; if (bus.scan_err !== 1'b0) begin errors++; $display("[TB] FAIL reset scan_err got=%b exp=0", bus.scan_err); end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_scan_1234();
        f0 = frames_seen;
        scan_frame(7'h30, 7'h24, 7'h79, 7'h19, 8);
        checks++; if (frames_seen !== f0 + 1) begin errors++; $display("[TB] FAIL s1234 frames got=%0d exp=%0d", frames_seen - f0, 1); end
        checks++; if (bus.hex0 !== 4'h3) begin errors++; $display("[TB] FAIL s1234 hex0 got=%h exp=3", bus.hex0); end
        checks++; if (bus.hex1 !== 4'h2) begin errors++; $display("[TB] FAIL s1234 hex1 got=%h exp=2", bus.hex1); end
        checks++; if (bus.hex2 !== 4'h1) begin errors++; $display("[TB] FAIL s1234 hex2 got=%h exp=1", bus.hex2); end
        checks++; if (bus.hex3 !== 4'h4) begin errors++; $display("[TB] FAIL s1234 hex3 got=%h exp=4", bus.hex3); end
        checks++; if (bus.digit2 !== 7'h79) begin errors++; $display("[TB] FAIL s1234 digit2 got=%h exp=79", bus.digit2); end
        checks++; if (bus.hex_valid !== 4'hF) begin errors++; $display("[TB] FAIL s1234 hex_valid got=%b exp=1111", bus.hex_valid); end
        checks++; if (stable_at_done !== 1'b0) begin errors++; $display("[TB] FAIL s1234 stable_at_done got=%b exp=0", stable_at_done); end
    endtask

    task automatic test_stable();
        scan_frame(7'h30, 7'h24, 7'h79, 7'h19, 8);
        checks++; if (stable_at_done !== 1'b1) begin errors++; $display("[TB] FAIL stable frame2 got=%b exp=1", stable_at_done); end
        scan_frame(7'h30, 7'h24, 7'h79, 7'h19, 8);
        checks++; if (bus.stable !== 1'b1) begin errors++; $display("[TB] FAIL stable frame3 got=%b exp=1", bus.stable); end
        f0 = frames_seen;
        scan_frame(7'h30, 7'h24, 7'h06, 7'h19, 8);
        checks++; if (frames_seen !== f0 + 1) begin errors++; $display("[TB] FAIL stable_change frames got=%0d exp=%0d", frames_seen - f0, 1); end
        checks++; if (bus.hex2 !== 4'hE) begin errors++; $display("[TB] FAIL stable_change hex2 got=%h exp=e", bus.hex2); end
        checks++; if (stable_at_done !== 1'b0) begin errors++; $display("[TB] FAIL stable_change stable_at_done got=%b exp=0", stable_at_done); end
        checks++; if (bus.stable !== 1'b0) begin errors++; $display("[TB] FAIL stable_change stable got=%b exp=0", bus.stable); end
    endtask

    task automatic test_glitch();
        apply_reset();
        f0 = frames_seen;
        dwell(4'b1110, 7'h30, 2);
        dwell(4'b1110, 7'h00, 2);
        dwell(4'b1110, 7'h30, 8);
        dwell(4'b1101, 7'h24, 8);
        dwell(4'b1011, 7'h79, 8);
        dwell(4'b0111, 7'h19, 8);
        dwell(4'b1111, 7'h7F, 3);
        checks++; if (frames_seen !== f0 + 1) begin errors++; $display("[TB] FAIL glitch frames got=%0d exp=%0d", frames_seen - f0, 1); end
        checks++; if (bus.digit0 !== 7'h30) begin errors++; $display("[TB] FAIL glitch digit0 got=%h exp=30", bus.digit0); end
        checks++; if (bus.hex0 !== 4'h3) begin errors++; $display("[TB] FAIL glitch hex0 got=%h exp=3", bus.hex0); end
        f0 = frames_seen;
        dwell(4'b1110, 7'h40, 3);
        dwell(4'b1101, 7'h24, 8);
        dwell(4'b1011, 7'h79, 8);
        dwell(4'b0111, 7'h19, 8);
        dwell(4'b1111, 7'h7F, 3);
        checks++; if (frames_seen !== f0) begin errors++; $display("[TB] FAIL short_dwell frames got=%0d exp=%0d", frames_seen - f0, 0); end
        dwell(4'b1110, 7'h40, 8);
        dwell(4'b1111, 7'h7F, 3);
        checks++; if (frames_seen !== f0 + 1) begin errors++; $display("[TB] FAIL short_dwell_fill frames got=%0d exp=%0d", frames_seen - f0, 1); end
        checks++; if (bus.digit0 !== 7'h40) begin errors++; $display("[TB] FAIL short_dwell_fill digit0 got=%h exp=40", bus.digit0); end
        checks++; if (bus.hex_valid !== 4'hF) begin errors++; $display("[TB] FAIL short_dwell_fill hex_valid got=%b exp=1111", bus.hex_valid); end
    endtask

    task automatic test_scan_err();
        f0 = frames_seen;
        dwell(4'b1100, 7'h40, 6);
        dwell(4'b1111, 7'h7F, 2);
        checks++; if (bus.scan_err !== 1'b1) begin errors++; $display("[TB] FAIL scan_err set got=%b exp=1", bus.scan_err); end
        checks++; if (frames_seen !== f0) begin errors++; $display("[TB] FAIL scan_err frames got=%0d exp=%0d", frames_seen - f0, 0); end
        scan_frame(7'h21, 7'h46, 7'h03, 7'h08, 8);
        checks++; if (frames_seen !== f0 + 1) begin errors++; $display("[TB] FAIL abcd frames got=%0d exp=%0d", frames_seen - f0, 1); end
        checks++; if (bus.hex0 !== 4'hD) begin errors++; $display("[TB] FAIL abcd hex0 got=%h exp=d", bus.hex0); end
        checks++; if (bus.hex1 !== 4'hC) begin errors++; $display("[TB] FAIL abcd hex1 got=%h exp=c", bus.hex1); end
        checks++; if (bus.hex2 !== 4'hB) begin errors++; $display("[TB] FAIL abcd hex2 got=%h exp=b", bus.hex2); end
        checks++; if (bus.hex3 !== 4'hA) begin errors++; $display("[TB] FAIL abcd hex3 got=%h exp=a", bus.hex3); end
        checks++; if (bus.hex_valid !== 4'hF) begin errors++; $display("[TB] FAIL abcd hex_valid got=%b exp=1111", bus.hex_valid); end
        checks++; if (bus.scan_err !== 1'b1) begin errors++; $display("[TB] FAIL scan_err sticky got=%b exp=1", bus.scan_err); end
    endtask

    task automatic test_illegal();
        scan_frame(7'h40, 7'h7E, 7'h24, 7'h30, 8);
        checks++; if (bus.digit1 !== 7'h7E) begin errors++; $display("[TB] FAIL illegal digit1 got=%h exp=7e", bus.digit1); end
        checks++; if (bus.hex1 !== 4'h0) begin errors++; $display("[TB] FAIL illegal hex1 got=%h exp=0", bus.hex1); end
        checks++; if (bus.hex2 !== 4'h2) begin errors++; $display("[TB] FAIL illegal hex2 got=%h exp=2", bus.hex2); end
        checks++; if (bus.hex3 !== 4'h3) begin errors++; $display("[TB] FAIL illegal hex3 got=%h exp=3", bus.hex3); end
        checks++; if (bus.hex_valid !== 4'b1101) begin errors++; $display("[TB] FAIL illegal hex_valid got=%b exp=1101", bus.hex_valid); end
    endtask

    task automatic test_back_to_back();
        f0 = frames_seen;
        scan_frame(7'h12, 7'h02, 7'h78, 7'h00, 5);
        checks++; if (frames_seen !== f0 + 1) begin errors++; $display("[TB] FAIL b2b frames got=%0d exp=%0d", frames_seen - f0, 1); end
        checks++; if (bus.hex0 !== 4'h5) begin errors++; $display("[TB] FAIL b2b hex0 got=%h exp=5", bus.hex0); end
        checks++; if (bus.hex1 !== 4'h6) begin errors++; $display("[TB] FAIL b2b hex1 got=%h exp=6", bus.hex1); end
        checks++; if (bus.hex2 !== 4'h7) begin errors++; $display("[TB] FAIL b2b hex2 got=%h exp=7", bus.hex2); end
        checks++; if (bus.hex3 !== 4'h8) begin errors++; $display("[TB] FAIL b2b hex3 got=%h exp=8", bus.hex3); end
    endtask

    task automatic test_reset_mid();
        dwell(4'b1110, 7'h40, 8);
        dwell(4'b1101, 7'h79, 8);
        dwell(4'b1011, 7'h24, 3);
        reset = 1'b1;
        #1;
        checks++; if (bus.digit1 !== 7'h7F) begin errors++; $display("[TB] FAIL mid_reset digit1 got=%h exp=7f", bus.digit1); end
        checks++; if (bus.hex_valid !== 4'h0) begin errors++; $display("[TB] FAIL mid_reset hex_valid got=%b exp=0000", bus.hex_valid); end
        checks++; if (bus.hex1 !== 4'h0) begin errors++; $display("[TB] FAIL mid_reset hex1 got=%h exp=0", bus.hex1); end
        checks++; if (bus.scan_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset scan_err got=%b exp=0", bus.scan_err); end
        checks++; if (bus.stable !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset stable got=%b exp=0", bus.stable); end
        bus.an      = 4'hF;
        bus.cathode = 7'h7F;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        f0 = frames_seen;
        dwell(4'b1011, 7'h24, 8);
        dwell(4'b0111, 7'h30, 8);
        dwell(4'b1111, 7'h7F, 3);
        checks++; if (frames_seen !== f0) begin errors++; $display("[TB] FAIL mid_reset partial frames got=%0d exp=%0d", frames_seen - f0, 0); end
        dwell(4'b1110, 7'h40, 8);
        dwell(4'b1101, 7'h79, 8);
        dwell(4'b1111, 7'h7F, 3);
        checks++; if (frames_seen !== f0 + 1) begin errors++; $display("[TB] FAIL mid_reset full frames got=%0d exp=%0d", frames_seen - f0, 1); end
        checks++; if (bus.hex0 !== 4'h0) begin errors++; $display("[TB] FAIL mid_reset hex0 got=%h exp=0", bus.hex0); end
        checks++; if (bus.hex1 !== 4'h1) begin errors++; $display("[TB] FAIL mid_reset hex1_after got=%h exp=1", bus.hex1); end
        checks++; if (bus.hex2 !== 4'h2) begin errors++; $display("[TB] FAIL mid_reset hex2 got=%h exp=2", bus.hex2); end
        checks++; if (bus.hex3 !== 4'h3) begin errors++; $display("[TB] FAIL mid_reset hex3 got=%h exp=3", bus.hex3); end
        checks++; if (bus.hex_valid !== 4'hF) begin errors++; $display("[TB] FAIL mid_reset hex_valid_after got=%b exp=1111", bus.hex_valid); end
        checks++; if (stable_at_done !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset stable_at_done got=%b exp=0", stable_at_done); end
    endtask

    // Run every scenario in order, then report
    initial begin
        errors         = 0;
        checks         = 0;
        frames_seen    = 0;
        stable_at_done = 1'b0;
        reset          = 1'b1;
        bus.an         = 4'hF;
        bus.cathode    = 7'h7F;
        @(negedge clk);
        test_reset();
        test_scan_1234();
        test_stable();
        test_glitch();
        test_scan_err();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
